// File: rtl/ysyx_22050368_idu_stage.sv
// ysyx_22050368_idu_stage: registered RV32I/RV64I decode stage with a 2-entry skid buffer and flush.
// Optional: define YSYX_22050368_IDU_MEXT_EN to decode M-extension (MULDIV) encodings instead of flagging them illegal.
module ysyx_22050368_idu_stage #(
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5,
  parameter int INST_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INST_WIDTH-1:0]  in_inst,
  input  logic [XLEN-1:0]        in_pc,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [RFIDX_WIDTH-1:0] dec_rs1idx,
  output logic [RFIDX_WIDTH-1:0] dec_rs2idx,
  output logic [RFIDX_WIDTH-1:0] dec_rdidx,
  output logic                   dec_rs1en,
  output logic                   dec_rs2en,
  output logic                   dec_rdwen,
  output logic                   dec_rs1x0,
  output logic                   dec_rs2x0,
  output logic [XLEN-1:0]        dec_imm,
  output logic [2:0]             dec_grp,
  output logic [2:0]             dec_funct3,
  output logic                   dec_alt,
  output logic                   dec_word,
  output logic                   dec_illegal
);
  localparam bit rv64 = (XLEN == 64);
  localparam logic [6:0] opc_lui    = 7'b0110111;
  localparam logic [6:0] opc_auipc  = 7'b0010111;
  localparam logic [6:0] opc_jal    = 7'b1101111;
  localparam logic [6:0] opc_jalr   = 7'b1100111;
  localparam logic [6:0] opc_branch = 7'b1100011;
  localparam logic [6:0] opc_load   = 7'b0000011;
  localparam logic [6:0] opc_store  = 7'b0100011;
  localparam logic [6:0] opc_opimm  = 7'b0010011;
  localparam logic [6:0] opc_op     = 7'b0110011;
  localparam logic [6:0] opc_fence  = 7'b0001111;
  localparam logic [6:0] opc_system = 7'b1110011;
  localparam logic [6:0] opc_opimm32 = 7'b0011011;
  localparam logic [6:0] opc_op32   = 7'b0111011;

  typedef struct packed {
    logic [XLEN-1:0]        pc;
    logic [RFIDX_WIDTH-1:0] rs1idx;
    logic [RFIDX_WIDTH-1:0] rs2idx;
    logic [RFIDX_WIDTH-1:0] rdidx;
    logic                   rs1en;
    logic                   rs2en;
    logic                   rdwen;
    logic                   rs1x0;
    logic                   rs2x0;
    logic [XLEN-1:0]        imm;
    logic [2:0]             grp;
    logic [2:0]             funct3;
    logic                   alt;
    logic                   word;
    logic                   illegal;
  } dec_t;

  logic [6:0] w_opc, w_f7;
  logic [2:0] w_f3;
  logic w_lui, w_auipc, w_jal, w_jalr, w_br, w_ld, w_st, w_opi, w_op, w_fence, w_sys, w_opi32, w_op32;
  logic w_known, w_muldiv, w_f7_ok, w_mext_bad, w_ill;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm32;
  logic w_acc;
  dec_t w_dec, r_or, r_sk;
  logic r_or_v, r_sk_v;

  assign w_opc = in_inst[6:0];
  assign w_f3  = in_inst[14:12];
  assign w_f7  = in_inst[31:25];

  assign w_lui   = w_opc == opc_lui;
  assign w_auipc = w_opc == opc_auipc;
  assign w_jal   = w_opc == opc_jal;
  assign w_jalr  = w_opc == opc_jalr;
  assign w_br    = w_opc == opc_branch;
  assign w_ld    = w_opc == opc_load;
  assign w_st    = w_opc == opc_store;
  assign w_opi   = w_opc == opc_opimm;
  assign w_op    = w_opc == opc_op;
  assign w_fence = w_opc == opc_fence;
  assign w_sys   = w_opc == opc_system;
  assign w_opi32 = w_opc == opc_opimm32;
  assign w_op32  = w_opc == opc_op32;

  assign w_known = w_lui | w_auipc | w_jal | w_jalr | w_br | w_ld | w_st | w_opi | w_op
                 | w_fence | w_sys | w_opi32 | w_op32;

  // OP-class funct7: base ops, SUB/SRA alternate, or the M-extension row
  assign w_muldiv = (w_op | w_op32) & (w_f7 == 7'b0000001);
  assign w_f7_ok  = (w_f7 == 7'b0) | ((w_f7 == 7'b0100000) & ((w_f3 == 3'b000) | (w_f3 == 3'b101))) | w_muldiv;

`ifdef YSYX_22050368_IDU_MEXT_EN
  assign w_mext_bad = 1'b0;
`else
  assign w_mext_bad = w_muldiv;
`endif

  // RV32 has no *-32 opcodes and only 5-bit shift amounts
  assign w_ill = !w_known
               | (!rv64 & (w_opi32 | w_op32))
               | (!rv64 & w_opi & ((w_f3 == 3'b001) | (w_f3 == 3'b101)) & in_inst[25])
               | ((w_op | w_op32) & !w_f7_ok)
               | w_mext_bad;

  assign w_imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
  assign w_imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign w_imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign w_imm_u = {in_inst[31:12], 12'b0};
  assign w_imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

  assign w_imm32 = w_ill ? 32'd0
                 : (w_opi | w_opi32 | w_ld | w_jalr | w_fence) ? w_imm_i
                 : w_st ? w_imm_s
                 : w_br ? w_imm_b
                 : (w_lui | w_auipc) ? w_imm_u
                 : w_jal ? w_imm_j
                 : 32'd0;

  // Combinational decode of the incoming instruction, captured on accept
  always_comb begin
    w_dec         = '0;
    w_dec.pc      = in_pc;
    w_dec.rs1idx  = RFIDX_WIDTH'(in_inst[19:15]);
    w_dec.rs2idx  = RFIDX_WIDTH'(in_inst[24:20]);
    w_dec.rdidx   = RFIDX_WIDTH'(in_inst[11:7]);
    w_dec.rs1x0   = in_inst[19:15] == 5'd0;
    w_dec.rs2x0   = in_inst[24:20] == 5'd0;
    w_dec.rs1en   = !w_ill & !(w_lui | w_auipc | w_jal);
    w_dec.rs2en   = !w_ill & (w_op | w_op32 | w_st | w_br);
    w_dec.rdwen   = !w_ill & !(w_st | w_br | w_fence | (w_sys & (w_f3 == 3'b000))) & (|in_inst[11:7]);
    w_dec.imm     = XLEN'($signed(w_imm32));
    w_dec.grp     = w_ill ? 3'b111
                  : w_muldiv ? 3'b100
                  : (w_jal | w_jalr | w_br) ? 3'b001
                  : (w_ld | w_st) ? 3'b010
                  : (w_sys | w_fence) ? 3'b011
                  : 3'b000;
    w_dec.funct3  = w_f3;
    w_dec.alt     = in_inst[30];
    w_dec.word    = rv64 & (w_opi32 | w_op32);
    w_dec.illegal = w_ill;
  end

  assign in_ready = !r_sk_v;
  assign w_acc    = in_valid & !r_sk_v & !flush;

  // Output register plus skid entry; OR is always older than SK, flush dominates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_or_v <= 1'b0;
      r_sk_v <= 1'b0;
      r_or   <= '0;
      r_sk   <= '0;
    end else if (flush) begin
      r_or_v <= 1'b0;
      r_sk_v <= 1'b0;
    end else if (!r_or_v | out_ready) begin
      r_or_v <= r_sk_v | w_acc;
      r_sk_v <= 1'b0;
      if (r_sk_v) r_or <= r_sk;
      else if (w_acc) r_or <= w_dec;
    end else if (w_acc) begin
      r_sk   <= w_dec;
      r_sk_v <= 1'b1;
    end
  end

  assign out_valid   = r_or_v;
  assign out_pc      = r_or.pc;
  assign dec_rs1idx  = r_or.rs1idx;
  assign dec_rs2idx  = r_or.rs2idx;
  assign dec_rdidx   = r_or.rdidx;
  assign dec_rs1en   = r_or.rs1en;
  assign dec_rs2en   = r_or.rs2en;
  assign dec_rdwen   = r_or.rdwen;
  assign dec_rs1x0   = r_or.rs1x0;
  assign dec_rs2x0   = r_or.rs2x0;
  assign dec_imm     = r_or.imm;
  assign dec_grp     = r_or.grp;
  assign dec_funct3  = r_or.funct3;
  assign dec_alt     = r_or.alt;
  assign dec_word    = r_or.word;
  assign dec_illegal = r_or.illegal;
endmodule

// File: tb/tb_ysyx_22050368_idu_stage.sv
// tb_ysyx_22050368_idu_stage: randomized check of the decode stage against a queue-based reference model.
module tb_ysyx_22050368_idu_stage;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, flush = 1'b0, out_valid, out_ready = 1'b0;
  logic [31:0] in_inst = '0, in_pc = '0, out_pc, dec_imm;
  logic [4:0] dec_rs1idx, dec_rs2idx, dec_rdidx;
  logic dec_rs1en, dec_rs2en, dec_rdwen, dec_rs1x0, dec_rs2x0, dec_alt, dec_word, dec_illegal;
  logic [2:0] dec_grp, dec_funct3;

  ysyx_22050368_idu_stage #(.XLEN(32), .RFIDX_WIDTH(5), .INST_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .dec_rs1idx(dec_rs1idx), .dec_rs2idx(dec_rs2idx), .dec_rdidx(dec_rdidx),
    .dec_rs1en(dec_rs1en), .dec_rs2en(dec_rs2en), .dec_rdwen(dec_rdwen),
    .dec_rs1x0(dec_rs1x0), .dec_rs2x0(dec_rs2x0), .dec_imm(dec_imm), .dec_grp(dec_grp),
    .dec_funct3(dec_funct3), .dec_alt(dec_alt), .dec_word(dec_word), .dec_illegal(dec_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, imm;
    logic [4:0] rs1, rs2, rd;
    logic rs1en, rs2en, rdwen, rs1x0, rs2x0, alt, word, ill;
    logic [2:0] grp, f3;
  } exp_t;

  exp_t q[$];
  int errors = 0, checks = 0;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, x, $time);
    end
  endtask

  // Reference decode written opcode-by-opcode from the ISA tables
  function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc);
    exp_t e;
    logic [2:0] f3;
    logic [6:0] f7;
    logic u1, u2, wr, ill;
    f3 = i[14:12];
    f7 = i[31:25];
    e.pc = pc; e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7];
    e.rs1x0 = i[19:15] == 5'd0; e.rs2x0 = i[24:20] == 5'd0;
    e.f3 = f3; e.alt = i[30]; e.word = 1'b0; e.grp = 3'd0; e.imm = 32'd0;
    u1 = 1'b1; u2 = 1'b0; wr = 1'b1; ill = 1'b0;
    case (i[6:0])
      7'h37, 7'h17: begin u1 = 1'b0; e.imm = {i[31:12], 12'h000}; end
      7'h6F: begin u1 = 1'b0; e.grp = 3'd1; e.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})); end
      7'h67: begin e.grp = 3'd1; e.imm = 32'($signed(i[31:20])); end
      7'h63: begin u2 = 1'b1; wr = 1'b0; e.grp = 3'd1; e.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})); end
      7'h03: begin e.grp = 3'd2; e.imm = 32'($signed(i[31:20])); end
      7'h23: begin u2 = 1'b1; wr = 1'b0; e.grp = 3'd2; e.imm = 32'($signed({i[31:25], i[11:7]})); end
      7'h13: begin e.imm = 32'($signed(i[31:20])); ill = (f3 == 3'd1 || f3 == 3'd5) && i[25]; end
      7'h33: begin
        u2 = 1'b1;
        if (f7 == 7'h01) begin
`ifdef YSYX_22050368_IDU_MEXT_EN
          e.grp = 3'd4;
`else
          ill = 1'b1;
`endif
        end else if (!(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) ill = 1'b1;
      end
      7'h0F: begin wr = 1'b0; e.grp = 3'd3; e.imm = 32'($signed(i[31:20])); end
      7'h73: begin wr = f3 != 3'd0; e.grp = 3'd3; end
      default: ill = 1'b1;
    endcase
    if (ill) begin e.grp = 3'd7; u1 = 1'b0; u2 = 1'b0; wr = 1'b0; end
    e.rs1en = u1; e.rs2en = u2; e.rdwen = wr && (i[11:7] != 5'd0); e.ill = ill;
    return e;
  endfunction

  // Per-cycle comparison of handshake and output register against the model queue
  task automatic check_model();
    exp_t e;
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    if (q.size() > 0) begin
      e = q[0];
      chk("out_pc", 64'(out_pc), 64'(e.pc));
      chk("rs1idx", 64'(dec_rs1idx), 64'(e.rs1));
      chk("rs2idx", 64'(dec_rs2idx), 64'(e.rs2));
      chk("rdidx", 64'(dec_rdidx), 64'(e.rd));
      chk("rs1en", 64'(dec_rs1en), 64'(e.rs1en));
      chk("rs2en", 64'(dec_rs2en), 64'(e.rs2en));
      chk("rdwen", 64'(dec_rdwen), 64'(e.rdwen));
      chk("rs1x0", 64'(dec_rs1x0), 64'(e.rs1x0));
      chk("rs2x0", 64'(dec_rs2x0), 64'(e.rs2x0));
      if (!e.ill) chk("imm", 64'(dec_imm), 64'(e.imm));
      chk("grp", 64'(dec_grp), 64'(e.grp));
      chk("funct3", 64'(dec_funct3), 64'(e.f3));
      chk("alt", 64'(dec_alt), 64'(e.alt));
      chk("word", 64'(dec_word), 64'(e.word));
      chk("illegal", 64'(dec_illegal), 64'(e.ill));
    end
  endtask

  // Drive one cycle of inputs, advance the model, then check on the next falling edge
  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc, input logic ordy, input logic fl);
    logic acc, drn;
    in_valid = v; in_inst = inst; in_pc = pc; out_ready = ordy; flush = fl;
    acc = v && (q.size() < 2) && !fl;
    drn = (q.size() > 0) && ordy;
    if (fl) q.delete();
    else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(model(inst, pc));
    end
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] i;
    logic [6:0] opcs [13];
    logic [6:0] f7s [4];
    opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h1B, 7'h3B};
    f7s = '{7'h00, 7'h20, 7'h01, 7'h00};
    i = $urandom;
    if ($urandom_range(0, 7) != 0) i[6:0] = opcs[$urandom_range(0, 12)];
    if ((i[6:0] == 7'h33 || i[6:0] == 7'h13) && $urandom_range(0, 3) != 0) i[31:25] = f7s[$urandom_range(0, 3)];
    return i;
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst grp", 64'(dec_grp), 64'd0);
    chk("rst out_pc", 64'(out_pc), 64'd0);
    chk("rst imm", 64'(dec_imm), 64'd0);
    chk("rst rdwen", 64'(dec_rdwen), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    step(1, 32'hFFF00093, 32'h80000000, 1, 0);
    chk("addi valid", 64'(out_valid), 64'd1);
    chk("addi rd", 64'(dec_rdidx), 64'd1);
    chk("addi rs1x0", 64'(dec_rs1x0), 64'd1);
    chk("addi en", 64'({dec_rs1en, dec_rs2en, dec_rdwen}), 64'b101);
    chk("addi imm", 64'(dec_imm), 64'hFFFFFFFF);
    chk("addi grp", 64'(dec_grp), 64'd0);
    chk("addi pc", 64'(out_pc), 64'h80000000);
    step(1, 32'h0021A423, 32'h80000004, 1, 0);
    chk("sw idx", 64'({dec_rs1idx, dec_rs2idx}), 64'({5'd3, 5'd2}));
    chk("sw en", 64'({dec_rs1en, dec_rs2en, dec_rdwen}), 64'b110);
    chk("sw imm", 64'(dec_imm), 64'd8);
    chk("sw grp/f3", 64'({dec_grp, dec_funct3}), 64'({3'b010, 3'b010}));
    step(1, 32'hFE000EE3, 32'h80000008, 1, 0);
    chk("beq imm", 64'(dec_imm), 64'hFFFFFFFC);
    chk("beq grp", 64'(dec_grp), 64'd1);
    chk("beq x0", 64'({dec_rs1x0, dec_rs2x0, dec_rdwen}), 64'b110);
    step(1, 32'h027302B3, 32'h8000000C, 1, 0);
`ifdef YSYX_22050368_IDU_MEXT_EN
    chk("mul grp", 64'({dec_illegal, dec_grp, dec_rdwen}), 64'({1'b0, 3'b100, 1'b1}));
`else
    chk("mul grp", 64'({dec_illegal, dec_grp, dec_rdwen}), 64'({1'b1, 3'b111, 1'b0}));
`endif
    step(0, 32'h0, 32'h0, 1, 0);
    step(1, 32'h00100093, 32'h100, 0, 0);
    step(1, 32'h00200093, 32'h104, 0, 0);
    chk("bp in_ready", 64'(in_ready), 64'd0);
    step(1, 32'h00300093, 32'h108, 0, 0);
    chk("bp hold A", 64'(out_pc), 64'h100);
    step(1, 32'h00300093, 32'h108, 1, 0);
    chk("bp B", 64'(out_pc), 64'h104);
    step(1, 32'h00300093, 32'h108, 1, 0);
    chk("bp C", 64'(out_pc), 64'h108);
    step(0, 32'h0, 32'h0, 1, 0);
    chk("bp empty", 64'(out_valid), 64'd0);
    step(1, 32'h00100093, 32'h200, 0, 0);
    step(1, 32'h00200093, 32'h204, 0, 0);
    step(1, 32'h00300093, 32'h208, 0, 1);
    chk("flush valid", 64'(out_valid), 64'd0);
    chk("flush ready", 64'(in_ready), 64'd1);
    step(0, 32'h0, 32'h0, 1, 0);
    chk("flush stale", 64'(out_valid), 64'd0);
    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 3) != 0, rand_inst(), $urandom & 32'hFFFFFFFC,
           $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
